// File: rtl/rtfitanium_pic_if.sv
// ============================================================================
// Module      : rtfitanium_pic_if
// Description : Slave bus bundle shared by the rtfItanium peripherals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rtfitanium_pic_if;
  logic        cs_i;
  logic        cyc_i;
  logic        stb_i;
  logic        ack_o;
  logic [3:0]  sel_i;
  logic        we_i;
  logic [5:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;

  modport master (
    output cs_i, cyc_i, stb_i, sel_i, we_i, adr_i, dat_i,
    input  ack_o, dat_o
  );

  modport slave (
    input  cs_i, cyc_i, stb_i, sel_i, we_i, adr_i, dat_i,
    output ack_o, dat_o
  );
endinterface

`default_nettype wire

// File: rtl/rtfitanium_pic.sv
// ============================================================================
// Module      : rtfitanium_pic
// Description : 16-source fixed-priority interrupt controller (PIT on 0-2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtfitanium_pic #(
  parameter int NSRC = 16
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  rtfitanium_pic_if.slave      bus,
  input  wire logic [NSRC-1:0] irq_i,
  output logic                 irq_o,
  output logic [3:0]           cause_o
);

  localparam logic [2:0] c_ADR_PEND  = 3'd0;
  localparam logic [2:0] c_ADR_EN    = 3'd1;
  localparam logic [2:0] c_ADR_EDGE  = 3'd2;
  localparam logic [2:0] c_ADR_CTRL  = 3'd3;
  localparam logic [2:0] c_ADR_CAUSE = 3'd4;

  logic [NSRC-1:0] r_s1;
  logic [NSRC-1:0] r_s2;
  logic [NSRC-1:0] r_s3;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_en;
  logic [NSRC-1:0] r_edge;
  logic            r_gie;
  logic            r_rdy;
  logic [31:0]     r_dat;
  logic            r_irq;
  logic [3:0]      r_cause;

  logic            w_cs;
  logic            w_wr;
  logic [2:0]      w_reg;
  logic [NSRC-1:0] w_lane_mask;
  logic [NSRC-1:0] w_wdata;
  logic            w_pend_wr;
  logic            w_cause_wr;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_pend_nxt;
  logic [NSRC-1:0] w_act;
  logic [3:0]      w_win;
  logic [31:0]     w_rd;
  logic            w_unused_ok;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign w_cs        = bus.cs_i & bus.cyc_i & bus.stb_i;
  assign w_wr        = w_cs & bus.we_i;
  assign w_reg       = bus.adr_i[4:2];
  assign w_lane_mask = {{8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};
  assign w_wdata     = bus.dat_i[NSRC-1:0];
  assign w_pend_wr   = w_wr & (w_reg == c_ADR_PEND)  & bus.sel_i[0];
  assign w_cause_wr  = w_wr & (w_reg == c_ADR_CAUSE) & bus.sel_i[0];

  // Writes ack immediately; reads need one cycle for the registered data.
  assign bus.ack_o = w_cs & (bus.we_i | r_rdy);
  assign bus.dat_o = r_dat;

  assign w_clr = (w_pend_wr  ? (w_wdata & w_lane_mask)            : '0)
               | (w_cause_wr ? (NSRC'(1) << bus.dat_i[3:0])       : '0);

  // ---------------------------------------------------------------------------
  // Per-source qualification: a new edge beats a simultaneous clear
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < NSRC; n++) begin : g_src
    assign w_rise[n]     = r_s2[n] & ~r_s3[n];
    assign w_pend_nxt[n] = r_edge[n] ? (w_rise[n] | (r_pend[n] & ~w_clr[n]))
                                     : r_s2[n];
  end

  // ---------------------------------------------------------------------------
  // Priority resolve: lowest-numbered active source wins
  // ---------------------------------------------------------------------------
  assign w_act = r_pend & r_en & {NSRC{r_gie}};

  always_comb begin
    w_win = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_win = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd = '0;
    case (w_reg)
      c_ADR_PEND:  w_rd = 32'(r_pend);
      c_ADR_EN:    w_rd = 32'(r_en);
      c_ADR_EDGE:  w_rd = 32'(r_edge);
      c_ADR_CTRL:  w_rd = {31'b0, r_gie};
      c_ADR_CAUSE: w_rd = {r_irq, 27'b0, r_cause};
      default:     w_rd = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Synchroniser and pending state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_pend <= '0;
    end else begin
      r_s1   <= irq_i;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= w_pend_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Software-visible control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en   <= '0;
      r_edge <= '1;
      r_gie  <= 1'b0;
    end else if (w_wr) begin
      if (w_reg == c_ADR_EN) begin
        r_en <= (r_en & ~w_lane_mask) | (w_wdata & w_lane_mask);
      end
      if (w_reg == c_ADR_EDGE) begin
        r_edge <= (r_edge & ~w_lane_mask) | (w_wdata & w_lane_mask);
      end
      if ((w_reg == c_ADR_CTRL) && bus.sel_i[0]) begin
        r_gie <= bus.dat_i[0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus read pipeline and CPU-facing outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdy   <= 1'b0;
      r_dat   <= '0;
      r_irq   <= 1'b0;
      r_cause <= '0;
    end else begin
      r_rdy   <= w_cs;
      if (w_cs) begin
        r_dat <= w_rd;
      end
      r_irq   <= |w_act;
      r_cause <= w_win;
    end
  end

  assign irq_o   = r_irq;
  assign cause_o = r_cause;

  assign w_unused_ok = ^{bus.adr_i[5], bus.adr_i[1:0], bus.sel_i[3:2],
                         bus.dat_i[31:NSRC]};

endmodule

`default_nettype wire

// File: tb/tb_rtfitanium_pic.sv
// ============================================================================
// Module      : tb_rtfitanium_pic
// Description : Scoreboard bench for the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtfitanium_pic;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] irq_i;
  logic        irq_o;
  logic [3:0]  cause_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  rtfitanium_pic_if bus ();

  rtfitanium_pic #(.NSRC(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus.slave),
    .irq_i   (irq_i),
    .irq_o   (irq_o),
    .cause_o (cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus_idle();
    bus.cs_i  = 1'b0;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.sel_i = 4'h0;
    bus.adr_i = 6'h0;
    bus.dat_i = 32'h0;
  endtask

  task automatic bus_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] sel);
    bus.cs_i  = 1'b1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.sel_i = sel;
    bus.adr_i = {1'b0, r, 2'b00};
    bus.dat_i = d;
    #1 check_val("wr_ack", {31'b0, bus.ack_o}, 32'd1);
    @(posedge clk_i);
    #1 bus_idle();
  endtask

  task automatic bus_read(input string tag, input logic [2:0] r, input logic [31:0] exp);
    logic        got;
    logic [31:0] want;
    exp_q.push_back(exp);
    @(posedge clk_i);
    #1;
    bus.cs_i  = 1'b1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.adr_i = {1'b0, r, 2'b00};
    #1 check_val({tag, "_ack1"}, {31'b0, bus.ack_o}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk_i);
      #1;
      if (bus.ack_o) got = 1'b1;
    end
    want = exp_q.pop_front();
    if (got) check_val(tag, bus.dat_o, want);
    else     check_val({tag, "_timeout"}, 32'd0, 32'd1);
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    irq_i = '0;
    bus_idle();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset defaults
    check_val("rst_irq",   {31'b0, irq_o},   32'd0);
    check_val("rst_cause", {28'b0, cause_o}, 32'd0);
    check_val("rst_dat",   bus.dat_o,        32'd0);
    bus_read("rst_pend",  3'd0, 32'h0000_0000);
    bus_read("rst_en",    3'd1, 32'h0000_0000);
    bus_read("rst_edge",  3'd2, 32'h0000_FFFF);
    bus_read("rst_ctrl",  3'd3, 32'h0000_0000);
    bus_read("rst_cause_reg", 3'd4, 32'h0000_0000);
    bus_read("rst_reg5",  3'd5, 32'h0000_0000);

    // PIT edge source on line 0
    bus_write(3'd1, 32'h0000_0001, 4'hF);
    bus_write(3'd3, 32'h0000_0001, 4'hF);
    irq_i[0] = 1'b1;
    step(3);
    check_val("pit_early", {31'b0, irq_o}, 32'd0);
    step(1);
    check_val("pit_irq",   {31'b0, irq_o},   32'd1);
    check_val("pit_cause", {28'b0, cause_o}, 32'd0);
    bus_write(3'd4, 32'h0000_0000, 4'h1);
    check_val("pit_eoi_same", {31'b0, irq_o}, 32'd1);
    step(1);
    check_val("pit_eoi_next", {31'b0, irq_o}, 32'd0);
    step(5);
    check_val("pit_held_no_reassert", {31'b0, irq_o}, 32'd0);
    bus_read("pit_pend", 3'd0, 32'h0000_0000);
    irq_i[0] = 1'b0;

    // Fixed priority between sources 2 and 5
    bus_write(3'd1, 32'h0000_FFFF, 4'hF);
    irq_i = 16'h0024;
    step(4);
    check_val("pri_irq",   {31'b0, irq_o},   32'd1);
    check_val("pri_cause", {28'b0, cause_o}, 32'd2);
    bus_write(3'd4, 32'h0000_0002, 4'h1);
    check_val("pri_cause_hold", {28'b0, cause_o}, 32'd2);
    step(1);
    check_val("pri_cause_next", {28'b0, cause_o}, 32'd5);
    check_val("pri_irq_next",   {31'b0, irq_o},   32'd1);
    bus_write(3'd4, 32'h0000_0005, 4'h1);
    step(1);
    check_val("pri_irq_done", {31'b0, irq_o}, 32'd0);
    irq_i = '0;

    // Level mode on source 3
    bus_write(3'd2, 32'h0000_FFF7, 4'hF);
    bus_write(3'd1, 32'h0000_0008, 4'hF);
    irq_i[3] = 1'b1;
    step(4);
    check_val("lvl_irq",   {31'b0, irq_o},   32'd1);
    check_val("lvl_cause", {28'b0, cause_o}, 32'd3);
    bus_write(3'd0, 32'h0000_0008, 4'h1);
    bus_read("lvl_pend", 3'd0, 32'h0000_0008);
    bus_read("lvl_edge", 3'd2, 32'h0000_FFF7);
    irq_i[3] = 1'b0;
    step(3);
    check_val("lvl_drop_hold", {31'b0, irq_o}, 32'd1);
    step(1);
    check_val("lvl_drop_low",  {31'b0, irq_o}, 32'd0);

    // Set/clear collision on source 1
    irq_i[1] = 1'b1;
    step(2);
    bus_write(3'd0, 32'h0000_0002, 4'h1);
    bus_read("coll_pend", 3'd0, 32'h0000_0002);
    bus_write(3'd0, 32'h0000_0002, 4'h1);
    bus_read("coll_clear", 3'd0, 32'h0000_0000);
    irq_i[1] = 1'b0;

    // Global mask and byte lanes
    bus_write(3'd3, 32'h0000_0000, 4'hF);
    bus_write(3'd1, 32'h0000_0010, 4'hF);
    irq_i[4] = 1'b1;
    step(4);
    check_val("gie_off_irq", {31'b0, irq_o}, 32'd0);
    bus_read("gie_pend", 3'd0, 32'h0000_0010);
    bus_write(3'd3, 32'h0000_0001, 4'hF);
    check_val("gie_same", {31'b0, irq_o}, 32'd0);
    step(1);
    check_val("gie_on_irq",   {31'b0, irq_o},   32'd1);
    check_val("gie_on_cause", {28'b0, cause_o}, 32'd4);
    bus_write(3'd1, 32'h0000_0000, 4'h0);
    bus_read("sel0_en", 3'd1, 32'h0000_0010);
    bus_write(3'd0, 32'h0000_0010, 4'h0);
    bus_read("sel0_pend", 3'd0, 32'h0000_0010);
    bus_write(3'd1, 32'h0000_FFFF, 4'h1);
    bus_read("lane_en", 3'd1, 32'h0000_00FF);
    bus_read("cause_reg", 3'd4, 32'h8000_0004);
    bus_read("reg6", 3'd6, 32'h0000_0000);
    bus_write(3'd4, 32'h0000_0004, 4'h1);
    step(1);
    check_val("eoi4_irq", {31'b0, irq_o}, 32'd0);
    irq_i = '0;

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rtfitanium_pic.md
# rtfItanium_pic

Programmable interrupt controller that consumes the PIT's `out0`–`out2` timer outputs and up to 13 further peripheral request lines. It synchronises and edge/level-qualifies each source, latches pending requests, and applies per-source and global enables. It resolves fixed priority and presents a single registered interrupt request plus cause number to the CPU. Software controls it over the same slave bus protocol as the other rtfItanium peripherals.

## Interface
Parameters:
- `NSRC`, 16: number of interrupt sources. Fixed at 16 in this version; source n maps to `irq_i[n]`, and sources 0–2 are PIT `out0`–`out2`.

Ports:
- `clk_i`  in  1  system clock. Single clock domain; all registers are on rising edge.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `cs_i`, `cyc_i`, `stb_i`  in  1 each  slave select. Access is valid when `cs = cs_i & cyc_i & stb_i`.
- `ack_o`  out  1  bus acknowledge.
- `sel_i`  in  4  byte lanes for writes.
- `we_i`  in  1  write enable.
- `adr_i`  in  6  byte address; `adr_i[4:2]` selects the register.
- `dat_i`  in  32  write data.
- `dat_o`  out  32  read data, registered.
- `irq_i`  in  16  raw request lines. May be asynchronous.
- `irq_o`  out  1  interrupt request to the CPU, registered.
- `cause_o`  out  4  number of the highest-priority active source, registered.

## Operation
Registers (`adr_i[4:2]`); bits [31:16] read 0:
- 0 PEND: pending bits, bits [15:0]. Read returns the pending bits. Writing 1 clears an edge-mode bit; level-mode bits ignore writes.
- 1 EN: per-source enable, bits [15:0], read-write.
- 2 EDGE: mode per source, bits [15:0], read-write. 1 = rising-edge, 0 = level-high.
- 3 CTRL: bit0 = global enable (GIE), read-write.
- 4 CAUSE: read returns `{irq_o, 27'b0, cause_o}`. Write clears the pending bit numbered by `dat_i[3:0]` if that source is edge-mode (end-of-interrupt).
- 5–7: read 0, writes ignored.

Write byte lanes:
- `sel_i[0]` gates bits [7:0]; `sel_i[1]` gates bits [15:8].
- For PEND and CAUSE writes, `sel_i[0]` must be set for the write to take effect.

Per-source path:
- Two-flop synchroniser: `s1 <= irq_i`, `s2 <= s1`, plus history flop `s3 <= s2`.
- Edge mode: `pend[n] <= pend[n] | (s2[n] & ~s3[n])`, minus any clear. A set in the same cycle as a clear wins (bit stays 1).
- Level mode: `pend[n] <= s2[n]` every cycle, regardless of clears.
- Changing EDGE from 0 to 1 leaves the current `pend` value in place. Changing it from 1 to 0 overwrites `pend` with `s2` on the next cycle.

Priority:
- `act = pend & EN`, gated by GIE.
- The lowest-numbered active bit wins; source 0 (PIT counter 0) has highest priority.
- `irq_o <= |act`.
- `cause_o <= index of winner`, or 0 when none is active.

Reset values:
- PEND, EN, CTRL = 0.
- EDGE = 16'hFFFF.
- s1/s2/s3 = 0.
- `irq_o` = 0, `cause_o` = 0, `dat_o` = 0.
- `ack_o` follows `cs` combinationally and is not reset.
- A reset mid-transaction discards any write in that cycle.

## Timing
Bus handshake:
- Write: `ack_o` = 1 in the same cycle as `cs & we_i`. The register updates at that clock edge.
- Read: `dat_o` is loaded at each edge from `adr_i` (while `cs`). `rdy <= cs`, and `ack_o = cs & rdy`, so a read acks in the second cycle of `cs`.
- Back-to-back reads require `cs` to drop between transactions.

Request latency:
- `irq_i` first high at edge N gives: s1 at N, s2 at N+1, `pend` at N+2, `irq_o`/`cause_o` at N+3.
- Pulses shorter than one clock may be missed. PIT outputs are synchronous and at least one cycle wide.

Clear and enable latency:
- A clear written at edge M drops `pend` at M. `irq_o` falls at M+1 if no other source is active; otherwise `cause_o` changes to the next winner at M+1.
- A write to EN or CTRL takes effect on `irq_o` one edge later.

## Test plan
- **Reset defaults:** assert `rst_i` for 2 cycles, then read all registers → PEND=0, EN=0, EDGE=0000FFFF, CTRL=0, CAUSE=0. `irq_o`=0.
- **PIT edge source:** EN=0x0001, CTRL=1. Raise `irq_i[0]` at edge N → `irq_o`=1 and `cause_o`=0 at N+3. Write CAUSE with 0 → `irq_o`=0 one cycle later. Hold `irq_i[0]` high → no re-assert.
- **Priority:** EN=0xFFFF, CTRL=1. Raise `irq_i[5]` and `irq_i[2]` together → `cause_o`=2. Clear 2 → `cause_o`=5 the next cycle. Clear 5 → `irq_o`=0.
- **Level mode:** EDGE=0xFFF7, EN=0x0008, CTRL=1. Hold `irq_i[3]` high → `irq_o`=1. Write PEND=0x0008 → PEND still 0x0008. Drop `irq_i` → `irq_o`=0 three cycles later.
- **Set/clear collision:** time a rising edge on `irq_i[1]` so its detect cycle coincides with a PEND write of 0x0002 → PEND bit 1 = 1 afterward.
- **Masking and bus acks:** GIE=0 with pending bit 4 and EN bit 4 set → `irq_o`=0. Set GIE → `irq_o`=1 one cycle later. Check write `ack_o` in cycle 1 and read `ack_o` in cycle 2; a write with `sel_i`=0 changes nothing.
